// File: rtl/micro_ucr_hash_pkg.sv
// Purpose: shared widths and FSM encoding for the hash array scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package micro_ucr_hash_pkg;

    localparam int ANCHO_BOUNTY = 24;
    localparam int ANCHO_NONCE  = 32;
    localparam int ANCHO_BLOQUE = 96;
    localparam int ANCHO_TARGET = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CARGA     = 2'd1,
        BUSQUEDA  = 2'd2,
        RESULTADO = 2'd3
    } estado_t;

    // Job payload forwarded to the array, kept together as one register.
    typedef struct packed {
        logic [ANCHO_BLOQUE-1:0] bloque_datos;
        logic [ANCHO_TARGET-1:0] target;
    } trabajo_t;

endpackage

// File: rtl/planificador_hash_generador_nonces.sv
// Purpose: per-lane starting nonces, lane i = base + i (mod 2^32).
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of base.
//
// Ports:
//   base  - first nonce of the job
//   lanes - packed lane nonces, lane i at [32*i +: 32]
module generador_nonces
    import micro_ucr_hash_pkg::*;
#(
    parameter int NUM_BLOQUES_PARALELOS = 4
) (
    input  logic [ANCHO_NONCE-1:0]                       base,
    output logic [ANCHO_NONCE*NUM_BLOQUES_PARALELOS-1:0] lanes
);

    always_comb begin
        lanes = '0;
        for (int i = 0; i < NUM_BLOQUES_PARALELOS; i++) begin
            // Plain 32-bit add: wraps past 0xFFFFFFFF with no carry out.
            lanes[ANCHO_NONCE*i +: ANCHO_NONCE] = base + ANCHO_NONCE'(i);
        end
    end

endmodule

// File: rtl/planificador_hash.sv
// Purpose: accepts one mining job, sequences the hash array (load, search, freeze) and returns one result.
// Latency: accept -> hash_inicio low in CICLOS_CARGA+1 edges; hit/abort/timeout -> res_valid in 1 edge.
// Backpressure: job_ready only in IDLE; result held stable in RESULTADO until res_ready.
//
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   job_*                   - job offer (valid/ready), data/target/nonce base/cycle budget (0 = unlimited)
//   abortar                 - cancel the running job (CARGA/BUSQUEDA only)
//   hash_*                  - array interface: load/hold, job data, per-lane nonces, bounty and hit in
//   res_*                   - result record (valid/ready), bounty, cycles, timeout and abort flags
//   ocupado                 - scheduler not idle
module planificador_hash
    import micro_ucr_hash_pkg::*;
#(
    parameter int NUM_BLOQUES_PARALELOS = 4,
    parameter int ANCHO_CICLOS          = 16,
    parameter int CICLOS_CARGA          = 1
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         job_valid,
    output logic                                         job_ready,
    input  logic [ANCHO_BLOQUE-1:0]                      job_bloque_datos,
    input  logic [ANCHO_TARGET-1:0]                      job_target,
    input  logic [ANCHO_NONCE-1:0]                       job_nonce_base,
    input  logic [ANCHO_CICLOS-1:0]                      job_max_ciclos,
    input  logic                                         abortar,
    output logic                                         hash_inicio,
    output logic [ANCHO_BLOQUE-1:0]                      hash_bloque_datos,
    output logic [ANCHO_TARGET-1:0]                      hash_target,
    output logic [ANCHO_NONCE*NUM_BLOQUES_PARALELOS-1:0] hash_nonce_iniciales,
    input  logic [ANCHO_BOUNTY-1:0]                      hash_bounty,
    input  logic                                         hash_terminado,
    output logic                                         res_valid,
    input  logic                                         res_ready,
    output logic [ANCHO_BOUNTY-1:0]                      res_bounty,
    output logic [ANCHO_CICLOS-1:0]                      res_ciclos,
    output logic                                         res_timeout,
    output logic                                         res_abortado,
    output logic                                         ocupado
);

    localparam int ANCHO_CARGA = (CICLOS_CARGA > 1) ? $clog2(CICLOS_CARGA) : 1;
    localparam logic [ANCHO_CARGA-1:0]  ULTIMO_CARGA = ANCHO_CARGA'(CICLOS_CARGA - 1);
    localparam logic [ANCHO_CICLOS-1:0] UNO_CICLOS   = ANCHO_CICLOS'(1);

    estado_t                                      estado, estado_sig;
    trabajo_t                                     trabajo_q;
    logic [ANCHO_CICLOS-1:0]                      max_ciclos_q;
    logic [ANCHO_CICLOS-1:0]                      contador_q;
    logic [ANCHO_CARGA-1:0]                       carga_q;
    logic [ANCHO_NONCE*NUM_BLOQUES_PARALELOS-1:0] lanes;

    logic                                         aceptar;
    logic                                         captura;
    logic [ANCHO_BOUNTY-1:0]                      bounty_sig;
    logic [ANCHO_CICLOS-1:0]                      ciclos_sig;
    logic                                         timeout_sig;
    logic                                         abortado_sig;

    generador_nonces #(
        .NUM_BLOQUES_PARALELOS(NUM_BLOQUES_PARALELOS)
    ) u_generador_nonces (
        .base  (job_nonce_base),
        .lanes (lanes)
    );

    assign job_ready         = (estado == IDLE);
    assign aceptar           = job_valid && job_ready;
    assign hash_bloque_datos = trabajo_q.bloque_datos;
    assign hash_target       = trabajo_q.target;

    // Next state plus the result record to capture on the edge that leaves
    // CARGA/BUSQUEDA for RESULTADO.
    always_comb begin
        estado_sig   = estado;
        captura      = 1'b0;
        bounty_sig   = '0;
        ciclos_sig   = '0;
        timeout_sig  = 1'b0;
        abortado_sig = 1'b0;
        case (estado)
            IDLE: begin
                if (aceptar) begin
                    estado_sig = CARGA;
                end
            end
            CARGA: begin
                // hash_terminado still reflects the previous job here.
                if (abortar) begin
                    estado_sig   = RESULTADO;
                    captura      = 1'b1;
                    abortado_sig = 1'b1;
                end else if (carga_q == ULTIMO_CARGA) begin
                    estado_sig = BUSQUEDA;
                end
            end
            BUSQUEDA: begin
                if (hash_terminado) begin
                    captura    = 1'b1;
                    bounty_sig = hash_bounty;
                    ciclos_sig = contador_q;
                end else if (abortar) begin
                    captura      = 1'b1;
                    abortado_sig = 1'b1;
                    ciclos_sig   = contador_q;
                end else if ((max_ciclos_q != '0) &&
                             (contador_q == max_ciclos_q - UNO_CICLOS)) begin
                    captura     = 1'b1;
                    timeout_sig = 1'b1;
                    ciclos_sig  = contador_q;
                end
                if (captura) begin
                    estado_sig = RESULTADO;
                end
            end
            RESULTADO: begin
                if (res_ready) begin
                    estado_sig = IDLE;
                end
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado               <= IDLE;
            hash_inicio          <= 1'b1;
            ocupado              <= 1'b0;
            res_valid            <= 1'b0;
            trabajo_q            <= '0;
            max_ciclos_q         <= '0;
            hash_nonce_iniciales <= '0;
            contador_q           <= '0;
            carga_q              <= '0;
            res_bounty           <= '0;
            res_ciclos           <= '0;
            res_timeout          <= 1'b0;
            res_abortado         <= 1'b0;
        end else begin
            estado      <= estado_sig;
            // Engines run only while searching; every other state holds them.
            hash_inicio <= (estado_sig != BUSQUEDA);
            ocupado     <= (estado_sig != IDLE);
            res_valid   <= (estado_sig == RESULTADO);

            if (aceptar) begin
                trabajo_q.bloque_datos <= job_bloque_datos;
                trabajo_q.target       <= job_target;
                max_ciclos_q           <= job_max_ciclos;
                hash_nonce_iniciales   <= lanes;
                carga_q                <= '0;
            end else if (estado == CARGA) begin
                carga_q <= carga_q + ANCHO_CARGA'(1);
            end

            // Zero on entry to BUSQUEDA; saturates so an unlimited search never wraps.
            if (estado != BUSQUEDA) begin
                contador_q <= '0;
            end else if (contador_q != '1) begin
                contador_q <= contador_q + UNO_CICLOS;
            end

            if (captura) begin
                res_bounty   <= bounty_sig;
                res_ciclos   <= ciclos_sig;
                res_timeout  <= timeout_sig;
                res_abortado <= abortado_sig;
            end
        end
    end

endmodule

// File: tb/tb_planificador_hash.sv
module tb_planificador_hash;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          job_valid;
    logic          job_ready;
    logic [95:0]   job_bloque_datos;
    logic [7:0]    job_target;
    logic [31:0]   job_nonce_base;
    logic [15:0]   job_max_ciclos;
    logic          abortar;
    logic          hash_inicio;
    logic [95:0]   hash_bloque_datos;
    logic [7:0]    hash_target;
    logic [127:0]  hash_nonce_iniciales;
    logic [23:0]   hash_bounty;
    logic          hash_terminado;
    logic          res_valid;
    logic          res_ready;
    logic [23:0]   res_bounty;
    logic [15:0]   res_ciclos;
    logic          res_timeout;
    logic          res_abortado;
    logic          ocupado;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    planificador_hash #(
        .NUM_BLOQUES_PARALELOS(4),
        .ANCHO_CICLOS(16),
        .CICLOS_CARGA(1)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_bloque_datos     (job_bloque_datos),
        .job_target           (job_target),
        .job_nonce_base       (job_nonce_base),
        .job_max_ciclos       (job_max_ciclos),
        .abortar              (abortar),
        .hash_inicio          (hash_inicio),
        .hash_bloque_datos    (hash_bloque_datos),
        .hash_target          (hash_target),
        .hash_nonce_iniciales (hash_nonce_iniciales),
        .hash_bounty          (hash_bounty),
        .hash_terminado       (hash_terminado),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_bounty           (res_bounty),
        .res_ciclos           (res_ciclos),
        .res_timeout          (res_timeout),
        .res_abortado         (res_abortado),
        .ocupado              (ocupado)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outcome of a job from its event times: the earliest of hit, abort and
    // budget expiry ends the search; ties resolve hit > abort > timeout.
    function automatic void model(input logic [15:0] budget, input int hit_at, input int abort_at,
                                  input bit abort_carga, input logic [23:0] bty,
                                  output int k, output logic [23:0] e_bty, output logic [15:0] e_cic,
                                  output bit e_to, output bit e_ab, output bit chk_cic);
        e_bty = '0; e_cic = '0; e_to = 1'b0; e_ab = 1'b0; chk_cic = 1'b1; k = -1;
        if (abort_carga) begin
            e_ab = 1'b1;
            return;
        end
        k = 1 << 30;
        if (hit_at >= 0 && hit_at < k) k = hit_at;
        if (abort_at >= 0 && abort_at < k) k = abort_at;
        if (budget != 0 && int'(budget) - 1 < k) k = int'(budget) - 1;
        if (k == hit_at) e_bty = bty;
        else if (k == abort_at) begin
            e_ab = 1'b1;
            chk_cic = 1'b0;
        end else e_to = 1'b1;
        e_cic = 16'(k);
    endfunction

    task automatic run_job(input logic [31:0] base, input logic [7:0] tgt, input logic [15:0] budget,
                           input int hit_at, input logic [23:0] bty, input int abort_at,
                           input bit stale, input bit abort_carga, input int hold);
        logic [95:0]  datos;
        logic [127:0] exp_lanes;
        int           k;
        logic [23:0]  e_bty;
        logic [15:0]  e_cic;
        bit           e_to, e_ab, chk_cic;
        datos = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) exp_lanes[32*i +: 32] = base + 32'(i);
        model(budget, hit_at, abort_at, abort_carga, bty, k, e_bty, e_cic, e_to, e_ab, chk_cic);

        chk("job_ready_idle", 128'(job_ready), 128'(1));
        job_valid        = 1'b1;
        job_bloque_datos = datos;
        job_target       = tgt;
        job_nonce_base   = base;
        job_max_ciclos   = budget;
        hash_terminado   = stale;
        abortar          = abort_carga;   // ignored while IDLE
        @(negedge clk);
        // CARGA: job registered, inputs now changed to garbage
        job_valid        = 1'b0;
        job_bloque_datos = {$urandom, $urandom, $urandom};
        job_target       = 8'($urandom);
        job_nonce_base   = $urandom;
        job_max_ciclos   = 16'($urandom);
        chk("carga_lanes", hash_nonce_iniciales, exp_lanes);
        chk("carga_target", 128'(hash_target), 128'(tgt));
        chk("carga_datos", 128'(hash_bloque_datos), 128'(datos));
        chk("carga_inicio", 128'(hash_inicio), 128'(1));
        chk("carga_ocupado", 128'(ocupado), 128'(1));
        chk("carga_job_ready", 128'(job_ready), 128'(0));
        hash_terminado = stale;
        abortar        = abort_carga;
        @(negedge clk);
        hash_terminado = 1'b0;
        abortar        = 1'b0;
        if (!abort_carga) begin
            for (int c = 0; c <= k; c++) begin
                chk("busq_inicio", 128'(hash_inicio), 128'(0));
                chk("busq_res_valid", 128'(res_valid), 128'(0));
                hash_terminado = (c == hit_at);
                abortar        = (c == abort_at);
                hash_bounty    = (c == hit_at) ? bty : 24'($urandom);
                @(negedge clk);
            end
            hash_terminado = 1'b0;
            abortar        = 1'b0;
        end
        for (int h = 0; h <= hold; h++) begin
            chk("res_valid", 128'(res_valid), 128'(1));
            chk("res_inicio", 128'(hash_inicio), 128'(1));
            chk("res_job_ready", 128'(job_ready), 128'(0));
            chk("res_ocupado", 128'(ocupado), 128'(1));
            chk("res_bounty", 128'(res_bounty), 128'(e_bty));
            chk("res_timeout", 128'(res_timeout), 128'(e_to));
            chk("res_abortado", 128'(res_abortado), 128'(e_ab));
            if (chk_cic) chk("res_ciclos", 128'(res_ciclos), 128'(e_cic));
            hash_terminado = 1'($urandom);
            abortar        = 1'($urandom);
            hash_bounty    = 24'($urandom);
            res_ready      = (h == hold);
            @(negedge clk);
        end
        res_ready      = 1'b0;
        hash_terminado = 1'b0;
        abortar        = 1'b0;
        chk("done_res_valid", 128'(res_valid), 128'(0));
        chk("done_job_ready", 128'(job_ready), 128'(1));
        chk("done_ocupado", 128'(ocupado), 128'(0));
        chk("done_inicio", 128'(hash_inicio), 128'(1));
    endtask

    initial begin
        reset_n          = 1'b0;
        job_valid        = 1'b0;
        job_bloque_datos = '0;
        job_target       = '0;
        job_nonce_base   = '0;
        job_max_ciclos   = '0;
        abortar          = 1'b0;
        hash_bounty      = '0;
        hash_terminado   = 1'b0;
        res_ready        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_job_ready", 128'(job_ready), 128'(1));
        chk("rst_inicio", 128'(hash_inicio), 128'(1));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_ocupado", 128'(ocupado), 128'(0));
        chk("rst_nonces", hash_nonce_iniciales, 128'(0));
        chk("rst_datos", 128'(hash_bloque_datos), 128'(0));
        chk("rst_target", 128'(hash_target), 128'(0));
        chk("rst_res", 128'({res_bounty, res_ciclos, res_timeout, res_abortado}), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Hit in the 6th search cycle
        run_job(32'h0000_0010, 8'h10, 16'd100, 5, 24'h00ABCD, -1, 1'b0, 1'b0, 0);
        // Nonce wrap, then hit
        run_job(32'hFFFF_FFFE, 8'h22, 16'd50, 2, 24'h123456, -1, 1'b0, 1'b0, 1);
        chk("wrap_lanes", hash_nonce_iniciales, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE);
        // Timeout with budget 8
        run_job(32'h1234_5678, 8'h01, 16'd8, -1, 24'h0, -1, 1'b0, 1'b0, 0);
        // Budget 1 times out in the first search cycle
        run_job(32'h0000_0100, 8'h02, 16'd1, -1, 24'h0, -1, 1'b0, 1'b0, 0);
        // Hit and abort together: hit wins
        run_job(32'hA5A5_0000, 8'h33, 16'd40, 3, 24'hBEEF01, 3, 1'b0, 1'b0, 0);
        // Hit on the last budget cycle beats timeout
        run_job(32'h0000_0200, 8'h44, 16'd6, 5, 24'h0F0F0F, -1, 1'b0, 1'b0, 0);
        // Stale terminado in CARGA ignored
        run_job(32'h0000_0300, 8'h55, 16'd30, 4, 24'h777777, -1, 1'b1, 1'b0, 0);
        // Abort in CARGA
        run_job(32'h0000_0400, 8'h66, 16'd30, -1, 24'h0, -1, 1'b0, 1'b1, 0);
        // Abort in search, unlimited budget
        run_job(32'h0000_0500, 8'h77, 16'd0, -1, 24'h0, 7, 1'b0, 1'b0, 0);
        // Unlimited budget runs well past any small count
        run_job(32'h0000_0600, 8'h88, 16'd0, 300, 24'hC0FFEE, -1, 1'b0, 1'b0, 0);
        // Result backpressure for 10 cycles
        run_job(32'h0000_0700, 8'h99, 16'd20, 2, 24'h0ABC00, -1, 1'b0, 1'b0, 10);

        // Reset during search
        chk("rstb_job_ready", 128'(job_ready), 128'(1));
        job_valid      = 1'b1;
        job_nonce_base = $urandom;
        job_max_ciclos = 16'd0;
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        chk("rstb_busq_inicio", 128'(hash_inicio), 128'(0));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstb_job_ready_after", 128'(job_ready), 128'(1));
        chk("rstb_inicio_after", 128'(hash_inicio), 128'(1));
        chk("rstb_res_valid_after", 128'(res_valid), 128'(0));
        chk("rstb_ocupado_after", 128'(ocupado), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized jobs against the model
        for (int t = 0; t < 25; t++) begin
            logic [15:0] budget;
            int          hit_at, abort_at;
            budget   = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            hit_at   = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 25));
            abort_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 25)) : -1;
            if (budget == 0 && hit_at < 0 && abort_at < 0) hit_at = int'($urandom_range(0, 25));
            run_job($urandom, 8'($urandom), budget, hit_at, 24'($urandom), abort_at,
                    1'($urandom), ($urandom % 8 == 0), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
